// File: rtl/pb_gesture_decoder.sv
// pb_gesture_decoder
// Classifies debounced push-button press/release pulses into short press,
// long press, auto-repeat and double-click gestures. Each gesture is posted
// as a 2-bit code into a depth-1 event slot with a valid/ack handshake.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_reset_n        asynchronous active-low reset
//   i_pb_down        one-cycle pulse, button pressed (debounced)
//   i_pb_up          one-cycle pulse, button released (debounced)
//   i_event_ack      consumer accepts the pending event
//   i_clear_overflow clears the sticky overflow flag
//   o_event_code     0 = short, 1 = long, 2 = double, 3 = repeat
//   o_event_valid    event pending, held until acked
//   o_overflow       sticky, an event was dropped
//   o_debug          {state[2:0], valid, overflow, code[1:0], i_pb_down}
module pb_gesture_decoder #(
  parameter int TICK_DIV     = 1000,
  parameter int LONG_TICKS   = 500,
  parameter int DOUBLE_TICKS = 250,
  parameter int REPEAT_TICKS = 100
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_pb_down,
  input  logic       i_pb_up,
  input  logic       i_event_ack,
  input  logic       i_clear_overflow,
  output logic [1:0] o_event_code,
  output logic       o_event_valid,
  output logic       o_overflow,
  output logic [7:0] o_debug
);

  localparam int                 PRESC_W    = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [31:0]        LONG_T     = 32'(LONG_TICKS);
  localparam logic [31:0]        DOUBLE_T   = 32'(DOUBLE_TICKS);
  localparam logic [31:0]        REPEAT_T   = 32'(REPEAT_TICKS);
  localparam bit                 REPEAT_EN  = (REPEAT_TICKS != 0);

  localparam logic [1:0] EV_SHORT  = 2'd0;
  localparam logic [1:0] EV_LONG   = 2'd1;
  localparam logic [1:0] EV_DOUBLE = 2'd2;
  localparam logic [1:0] EV_REPEAT = 2'd3;

  // IDLE must encode as 0 so that o_debug reads 0 out of reset.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESSED1  = 3'd1,
    S_LONG_HELD = 3'd2,
    S_RELEASED1 = 3'd3,
    S_PRESSED2  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PRESC_W-1:0] r_presc;
  logic [15:0]        r_tick;
  logic [1:0]         r_code;
  logic               r_valid;
  logic               r_overflow;

  logic               w_down;
  logic               w_up;
  logic               w_tick_evt;
  logic [15:0]        w_tick_inc;
  logic [15:0]        w_tick_nxt;
  logic               w_hit_long;
  logic               w_hit_double;
  logic               w_hit_repeat;
  logic               w_post;
  logic [1:0]         w_post_code;
  logic               w_restart;
  logic               w_clr_cnt;
  logic               w_drop;

  // Simultaneous press and release pulses are contradictory; drop both.
  assign w_down = i_pb_down & ~i_pb_up;
  assign w_up   = i_pb_up & ~i_pb_down;

  // Thresholds are judged on the value the tick count takes at this edge, so
  // an event lands exactly on edge N*TICK_DIV after the counters cleared.
  assign w_tick_evt   = (r_presc == PRESC_LAST);
  assign w_tick_inc   = (r_tick == 16'hFFFF) ? r_tick : r_tick + 16'd1;
  assign w_tick_nxt   = w_tick_evt ? w_tick_inc : r_tick;
  assign w_hit_long   = w_tick_evt && ({16'd0, w_tick_nxt} == LONG_T);
  assign w_hit_double = w_tick_evt && ({16'd0, w_tick_nxt} == DOUBLE_T);
  assign w_hit_repeat = REPEAT_EN && w_tick_evt && ({16'd0, w_tick_nxt} == REPEAT_T);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Button pulses are checked before the timers so that a release on the
  // long edge, or a press on the window-expiry edge, takes precedence.
  always_comb begin
    w_state_nxt = r_state;
    w_post      = 1'b0;
    w_post_code = EV_SHORT;
    w_restart   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_down) begin
          w_state_nxt = S_PRESSED1;
        end
      end
      S_PRESSED1: begin
        if (w_up) begin
          w_state_nxt = S_RELEASED1;
        end else if (w_hit_long) begin
          w_state_nxt = S_LONG_HELD;
          w_post      = 1'b1;
          w_post_code = EV_LONG;
        end
      end
      S_LONG_HELD: begin
        if (w_up) begin
          w_state_nxt = S_IDLE;
        end else if (w_hit_repeat) begin
          w_post      = 1'b1;
          w_post_code = EV_REPEAT;
          w_restart   = 1'b1;
        end
      end
      S_RELEASED1: begin
        if (w_down) begin
          w_state_nxt = S_PRESSED2;
          w_post      = 1'b1;
          w_post_code = EV_DOUBLE;
        end else if (w_hit_double) begin
          w_state_nxt = S_IDLE;
          w_post      = 1'b1;
          w_post_code = EV_SHORT;
        end
      end
      S_PRESSED2: begin
        if (w_up) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Timing restarts on every state change and after each repeat.
  assign w_clr_cnt = (w_state_nxt != r_state) || w_restart;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_presc <= '0;
      r_tick  <= 16'd0;
    end else if (w_clr_cnt) begin
      r_presc <= '0;
      r_tick  <= 16'd0;
    end else if (w_tick_evt) begin
      r_presc <= '0;
      r_tick  <= w_tick_inc;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Depth-1 slot: the oldest unacked event is kept, newer ones are dropped.
  assign w_drop = w_post && r_valid && !i_event_ack;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_code  <= EV_SHORT;
      r_valid <= 1'b0;
    end else if (w_post) begin
      if (!r_valid || i_event_ack) begin
        r_code  <= w_post_code;
        r_valid <= 1'b1;
      end
    end else if (i_event_ack) begin
      r_valid <= 1'b0;
    end
  end

  // A fresh drop outranks a clear request in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_event_code  = r_code;
  assign o_event_valid = r_valid;
  assign o_overflow    = r_overflow;
  assign o_debug       = {r_state, r_valid, r_overflow, r_code, i_pb_down};

endmodule

// File: tb/tb_pb_gesture_decoder.sv
module tb_pb_gesture_decoder;

  localparam int TD = 4;
  localparam int LT = 5;
  localparam int DT = 3;
  localparam int RT = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pb_down = 1'b0;
  logic       pb_up = 1'b0;
  logic       ack = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] code;
  logic       valid;
  logic       ovf;
  logic [7:0] dbg;

  pb_gesture_decoder #(
    .TICK_DIV    (TD),
    .LONG_TICKS  (LT),
    .DOUBLE_TICKS(DT),
    .REPEAT_TICKS(RT)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_pb_down       (pb_down),
    .i_pb_up         (pb_up),
    .i_event_ack     (ack),
    .i_clear_overflow(clr),
    .o_event_code    (code),
    .o_event_valid   (valid),
    .o_overflow      (ovf),
    .o_debug         (dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: gesture phase plus cycles elapsed since the last restart.
  // Phases: 0 idle, 1 first hold, 2 long hold, 3 released, 4 second hold.
  int m_ph;
  int m_t;
  int m_valid;
  int m_code;
  int m_ovf;

  int e_idx;
  int prev_valid;
  int rise_e[$];
  int rise_c[$];

  typedef struct {
    int dn1;
    int up1;
    int dn2;
    int up2;
    int exp_edge;
    int exp_code;
    int exp_ovf;
  } row_t;

  row_t rows[6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_t = 0; m_valid = 0; m_code = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input int d, input int u, input int a, input int c);
    int dn, upp, post, pc, drop;
    dn = (d != 0 && u == 0) ? 1 : 0;
    upp = (u != 0 && d == 0) ? 1 : 0;
    post = 0; pc = 0; drop = 0;
    m_t++;
    case (m_ph)
      0: if (dn != 0) begin m_ph = 1; m_t = 0; end
      1: begin
        if (upp != 0) begin m_ph = 3; m_t = 0; end
        else if (m_t == LT * TD) begin m_ph = 2; m_t = 0; post = 1; pc = 1; end
      end
      2: begin
        if (upp != 0) begin m_ph = 0; m_t = 0; end
        else if (RT != 0 && m_t == RT * TD) begin m_t = 0; post = 1; pc = 3; end
      end
      3: begin
        if (dn != 0) begin m_ph = 4; m_t = 0; post = 1; pc = 2; end
        else if (m_t == DT * TD) begin m_ph = 0; m_t = 0; post = 1; pc = 0; end
      end
      default: if (upp != 0) begin m_ph = 0; m_t = 0; end
    endcase
    if (post != 0) begin
      if (m_valid == 0 || a != 0) begin m_code = pc; m_valid = 1; end
      else drop = 1;
    end else if (a != 0) begin
      m_valid = 0;
    end
    if (drop != 0) m_ovf = 1;
    else if (c != 0) m_ovf = 0;
  endtask

  task automatic step(input int d, input int u, input int a, input int c);
    pb_down = (d != 0); pb_up = (u != 0); ack = (a != 0); clr = (c != 0);
    @(posedge clk);
    model_edge(d, u, a, c);
    #1;
    chk("valid", int'(valid), m_valid);
    chk("code", int'(code), m_code);
    chk("overflow", int'(ovf), m_ovf);
    chk("debug_low", int'(dbg[4:0]), (m_valid << 4) | (m_ovf << 3) | (m_code << 1) | ((d != 0) ? 1 : 0));
    chk("debug_idle", (dbg[7:5] == 3'd0) ? 1 : 0, (m_ph == 0) ? 1 : 0);
    if (valid && prev_valid == 0) begin
      rise_e.push_back(e_idx);
      rise_c.push_back(int'(code));
    end
    prev_valid = int'(valid);
    e_idx++;
  endtask

  task automatic do_reset();
    pb_down = 1'b0; pb_up = 1'b0; ack = 1'b0; clr = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("reset_valid", int'(valid), 0);
    chk("reset_code", int'(code), 0);
    chk("reset_overflow", int'(ovf), 0);
    chk("reset_debug", int'(dbg), 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    prev_valid = 0;
    e_idx = 0;
    rise_e.delete();
    rise_c.delete();
  endtask

  initial begin
    int exp_e[3];
    int exp_c[3];
    int d, u, a, c;

    rows[0] = '{dn1: 0, up1: 10, dn2: -1, up2: -1, exp_edge: 22, exp_code: 0, exp_ovf: 0};
    rows[1] = '{dn1: 0, up1: -1, dn2: -1, up2: -1, exp_edge: 20, exp_code: 1, exp_ovf: 1};
    rows[2] = '{dn1: 0, up1: 8,  dn2: 15, up2: 20, exp_edge: 15, exp_code: 2, exp_ovf: 0};
    rows[3] = '{dn1: 0, up1: 20, dn2: -1, up2: -1, exp_edge: 32, exp_code: 0, exp_ovf: 0};
    rows[4] = '{dn1: 0, up1: 8,  dn2: 20, up2: 25, exp_edge: 20, exp_code: 2, exp_ovf: 0};
    rows[5] = '{dn1: 0, up1: 0,  dn2: -1, up2: -1, exp_edge: -1, exp_code: 0, exp_ovf: 0};

    #1;
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

    // Single gestures with no acknowledge, 40 edges each.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int e = 0; e < 40; e++) begin
        d = (e == rows[r].dn1 || e == rows[r].dn2) ? 1 : 0;
        u = (e == rows[r].up1 || e == rows[r].up2) ? 1 : 0;
        step(d, u, 0, 0);
      end
      if (rows[r].exp_edge < 0) begin
        chk($sformatf("row%0d_no_event", r), rise_e.size(), 0);
      end else begin
        chk($sformatf("row%0d_rise_count", r), rise_e.size(), 1);
        if (rise_e.size() > 0) begin
          chk($sformatf("row%0d_rise_edge", r), rise_e[0], rows[r].exp_edge);
          chk($sformatf("row%0d_rise_code", r), rise_c[0], rows[r].exp_code);
        end
      end
      chk($sformatf("row%0d_overflow", r), int'(ovf), rows[r].exp_ovf);
    end

    // Long press with repeat, each event acked on the following edge.
    exp_e = '{20, 28, 36};
    exp_c = '{1, 3, 3};
    do_reset();
    for (int e = 0; e < 60; e++) begin
      step((e == 0) ? 1 : 0, (e == 38) ? 1 : 0, int'(valid), 0);
    end
    chk("repeat_count", rise_e.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < rise_e.size()) begin
        chk($sformatf("repeat%0d_edge", k), rise_e[k], exp_e[k]);
        chk($sformatf("repeat%0d_code", k), rise_c[k], exp_c[k]);
      end
    end

    // Handshake corners: post with ack, drop, clear, clear colliding with drop.
    do_reset();
    for (int e = 0; e < 48; e++) begin
      a = (e == 28 || e == 47) ? 1 : 0;
      c = (e == 37 || e == 44) ? 1 : 0;
      step((e == 0) ? 1 : 0, (e == 46) ? 1 : 0, a, c);
      if (e == 20) begin
        chk("hs_long_valid", int'(valid), 1);
        chk("hs_long_code", int'(code), 1);
      end
      if (e == 28) begin
        chk("hs_post_ack_valid", int'(valid), 1);
        chk("hs_post_ack_code", int'(code), 3);
        chk("hs_post_ack_ovf", int'(ovf), 0);
      end
      if (e == 36) chk("hs_drop_ovf", int'(ovf), 1);
      if (e == 37) chk("hs_clear_ovf", int'(ovf), 0);
      if (e == 44) chk("hs_clear_vs_drop_ovf", int'(ovf), 1);
      if (e == 47) chk("hs_ack_clears_valid", int'(valid), 0);
    end

    // Reset mid-gesture discards a pending event and the held press.
    do_reset();
    for (int e = 0; e < 21; e++) begin
      step((e == 0 || e == 16) ? 1 : 0, (e == 2) ? 1 : 0, 0, 0);
    end
    chk("abort_pending_valid", int'(valid), 1);
    chk("abort_pending_code", int'(code), 0);
    #2;
    do_reset();
    for (int e = 0; e < 40; e++) step(0, (e == 5) ? 1 : 0, 0, 0);
    chk("abort_no_event", rise_e.size(), 0);

    // Random pulses checked edge by edge against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      d = ($urandom_range(15) == 0) ? 1 : 0;
      u = ($urandom_range(15) == 0) ? 1 : 0;
      a = ($urandom_range(5) == 0) ? 1 : 0;
      c = ($urandom_range(19) == 0) ? 1 : 0;
      step(d, u, a, c);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
